// File: rtl/kl_diag_pkg.sv
// Shared definitions for the KL10 diagnostic DRAM write path: function codes,
// sequencer state encodings, DRAM word field widths and the parity helper.
package kl_diag_pkg;

  // Diagnostic function codes used by the DRAM write sequence
  localparam logic [0:6] FUNC_IR_LOAD  = 7'o057;
  localparam logic [0:6] FUNC_XY_EVEN  = 7'o060;
  localparam logic [0:6] FUNC_XY_ODD   = 7'o061;
  localparam logic [0:6] FUNC_J_COMMON = 7'o062;
  localparam logic [0:6] FUNC_J_EVEN   = 7'o063;
  localparam logic [0:6] FUNC_J_ODD    = 7'o064;

  // DRAM word field widths
  localparam int A_W  = 3;
  localparam int B_W  = 3;
  localparam int JC_W = 4;
  localparam int JW_W = 4;

  // Sequencer steps; each step between IDLE and FIN issues one function
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IR   = 3'd1,
    ST_XYE  = 3'd2,
    ST_XYO  = 3'd3,
    ST_JC   = 3'd4,
    ST_JE   = 3'd5,
    ST_JO   = 3'd6,
    ST_FIN  = 3'd7
  } state_e;

  // Phases inside one step
  typedef enum logic [1:0] {
    PH_SETUP  = 2'd0,
    PH_STROBE = 2'd1,
    PH_HOLD   = 2'd2
  } phase_e;

  // Odd parity over one DRAM word: the returned bit makes the total count of
  // ones across A, B, P, J common and J word odd.
  function automatic logic dram_odd_parity(
    input logic [0:A_W-1]  a,
    input logic [0:B_W-1]  b,
    input logic [1:JC_W]   jc,
    input logic [7:6+JW_W] jw
  );
    return ~^{a, b, jc, jw};
  endfunction

endpackage

// File: rtl/dram_parity_gen.sv
// Combinational odd-parity generator for one DRAM word.
module dram_parity_gen
  import kl_diag_pkg::*;
(
  input  logic [0:A_W-1]  a,
  input  logic [0:B_W-1]  b,
  input  logic [1:JC_W]   jc,
  input  logic [7:6+JW_W] jw,
  output logic            p
);

  assign p = dram_odd_parity(a, b, jc, jw);

endmodule

// File: rtl/dram_loader.sv
// Diagnostic DRAM write sequencer: captures one even/odd DRAM word pair and
// issues IR load, XY even, XY odd, J common, J even and J odd on the EBUS,
// each as a setup / strobe / hold step with all outputs registered.
module dram_loader
  import kl_diag_pkg::*;
#(
  parameter int         SETUP_CYCLES  = 1,
  parameter int         STROBE_CYCLES = 2,
  parameter logic [0:6] IR_LOAD_FUNC  = FUNC_IR_LOAD
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [0:8]      addr,
  input  logic [0:A_W-1]  evenA,
  input  logic [0:A_W-1]  oddA,
  input  logic [0:B_W-1]  evenB,
  input  logic [0:B_W-1]  oddB,
  input  logic [1:JC_W]   jCommon,
  input  logic [7:6+JW_W] evenJ,
  input  logic [7:6+JW_W] oddJ,
  output logic [0:35]     EBUS,
  output logic            drivingEBUS,
  output logic [0:6]      diagFunc,
  output logic            diagStrobe,
  output logic            busy,
  output logic            done,
  output logic            aborted
);

  // Phase counter counts down from (phase length - 1) to zero
  localparam int MAX_PHASE = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int CNT_W     = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;
  localparam logic [CNT_W-1:0] SETUP_INIT  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_INIT = CNT_W'(STROBE_CYCLES - 1);

  state_e             state_r;
  phase_e             phase_r;
  logic [CNT_W-1:0]   cnt_r;

  logic [0:A_W-1]     even_a_r;
  logic [0:A_W-1]     odd_a_r;
  logic [0:B_W-1]     even_b_r;
  logic [0:B_W-1]     odd_b_r;
  logic [1:JC_W]      j_common_r;
  logic [7:6+JW_W]    even_j_r;
  logic [7:6+JW_W]    odd_j_r;

  logic [0:35]        ebus_r;
  logic               driving_r;
  logic [0:6]         func_r;
  logic               strobe_r;
  logic               busy_r;
  logic               done_r;
  logic               aborted_r;

  logic               even_p_s;
  logic               odd_p_s;
  logic [0:8]         ir_addr_s;
  state_e             next_state_s;
  logic [0:6]         next_func_s;
  logic [0:35]        next_ebus_s;

  // The pair address always names the even word, so its low bit is dropped
  assign ir_addr_s = addr & 9'o776;

  dram_parity_gen u_even_parity (
    .a  (even_a_r),
    .b  (even_b_r),
    .jc (j_common_r),
    .jw (even_j_r),
    .p  (even_p_s)
  );

  dram_parity_gen u_odd_parity (
    .a  (odd_a_r),
    .b  (odd_b_r),
    .jc (j_common_r),
    .jw (odd_j_r),
    .p  (odd_p_s)
  );

  // Contents of the step that follows the current one, from captured fields
  always_comb begin
    next_state_s = ST_IDLE;
    next_func_s  = 7'o000;
    next_ebus_s  = 36'o0;
    case (state_r)
      ST_IR: begin
        next_state_s = ST_XYE;
        next_func_s  = FUNC_XY_EVEN;
        next_ebus_s  = {even_a_r, even_b_r, even_p_s, 29'b0};
      end
      ST_XYE: begin
        next_state_s = ST_XYO;
        next_func_s  = FUNC_XY_ODD;
        next_ebus_s  = {odd_a_r, odd_b_r, odd_p_s, 29'b0};
      end
      ST_XYO: begin
        next_state_s = ST_JC;
        next_func_s  = FUNC_J_COMMON;
        next_ebus_s  = {j_common_r, 32'b0};
      end
      ST_JC: begin
        next_state_s = ST_JE;
        next_func_s  = FUNC_J_EVEN;
        next_ebus_s  = {even_j_r, 32'b0};
      end
      ST_JE: begin
        next_state_s = ST_JO;
        next_func_s  = FUNC_J_ODD;
        next_ebus_s  = {odd_j_r, 32'b0};
      end
      ST_JO: begin
        next_state_s = ST_FIN;
        next_func_s  = 7'o000;
        next_ebus_s  = 36'o0;
      end
      default: begin
        next_state_s = ST_IDLE;
        next_func_s  = 7'o000;
        next_ebus_s  = 36'o0;
      end
    endcase
  end

  // Step/phase sequencer with registered EBUS, function and handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      phase_r    <= PH_SETUP;
      cnt_r      <= '0;
      even_a_r   <= 3'b000;
      odd_a_r    <= 3'b000;
      even_b_r   <= 3'b000;
      odd_b_r    <= 3'b000;
      j_common_r <= 4'b0000;
      even_j_r   <= 4'b0000;
      odd_j_r    <= 4'b0000;
      ebus_r     <= 36'o0;
      driving_r  <= 1'b0;
      func_r     <= 7'o000;
      strobe_r   <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      aborted_r  <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          strobe_r <= 1'b0;
          if (start) begin
            even_a_r   <= evenA;
            odd_a_r    <= oddA;
            even_b_r   <= evenB;
            odd_b_r    <= oddB;
            j_common_r <= jCommon;
            even_j_r   <= evenJ;
            odd_j_r    <= oddJ;
            state_r    <= ST_IR;
            phase_r    <= PH_SETUP;
            cnt_r      <= SETUP_INIT;
            driving_r  <= 1'b1;
            func_r     <= IR_LOAD_FUNC;
            ebus_r     <= {ir_addr_s, 27'b0};
            busy_r     <= 1'b1;
          end else begin
            driving_r <= 1'b0;
            func_r    <= 7'o000;
            ebus_r    <= 36'o0;
            busy_r    <= 1'b0;
          end
        end

        ST_IR, ST_XYE, ST_XYO, ST_JC, ST_JE, ST_JO: begin
          if (abort) begin
            // Cancel wins over any phase advance on this edge
            state_r   <= ST_IDLE;
            phase_r   <= PH_SETUP;
            cnt_r     <= '0;
            driving_r <= 1'b0;
            strobe_r  <= 1'b0;
            func_r    <= 7'o000;
            ebus_r    <= 36'o0;
            busy_r    <= 1'b0;
            aborted_r <= 1'b1;
          end else begin
            case (phase_r)
              PH_SETUP: begin
                if (cnt_r == '0) begin
                  phase_r  <= PH_STROBE;
                  cnt_r    <= STROBE_INIT;
                  strobe_r <= 1'b1;
                end else begin
                  cnt_r <= cnt_r - 1'b1;
                end
              end
              PH_STROBE: begin
                if (cnt_r == '0) begin
                  phase_r  <= PH_HOLD;
                  strobe_r <= 1'b0;
                end else begin
                  cnt_r <= cnt_r - 1'b1;
                end
              end
              PH_HOLD: begin
                // Data changes only after the hold cycle; JO's successor is FIN
                state_r   <= next_state_s;
                phase_r   <= PH_SETUP;
                cnt_r     <= SETUP_INIT;
                func_r    <= next_func_s;
                ebus_r    <= next_ebus_s;
                driving_r <= (next_state_s != ST_FIN);
                done_r    <= (next_state_s == ST_FIN);
              end
              default: begin
                phase_r  <= PH_HOLD;
                strobe_r <= 1'b0;
              end
            endcase
          end
        end

        ST_FIN: begin
          // The sequence has completed; a late cancel has nothing to undo
          state_r   <= ST_IDLE;
          driving_r <= 1'b0;
          strobe_r  <= 1'b0;
          busy_r    <= 1'b0;
        end

        default: begin
          state_r   <= ST_IDLE;
          phase_r   <= PH_SETUP;
          driving_r <= 1'b0;
          strobe_r  <= 1'b0;
          func_r    <= 7'o000;
          ebus_r    <= 36'o0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign EBUS        = ebus_r;
  assign drivingEBUS = driving_r;
  assign diagFunc    = func_r;
  assign diagStrobe  = strobe_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign aborted     = aborted_r;

endmodule
